// File: rtl/apb_uart_pkg.sv
// Shared definitions for the UART register map and the TX feeder state machine.
package apb_uart_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_BAUD   = 8'h04;
  localparam logic [7:0] ADDR_DATA   = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;

  localparam int TX_BUSY_BIT = 0;

  localparam logic [31:0] CTRL_ENABLE = 32'h0000_0001;

  typedef enum logic [2:0] {
    ST_RST_WAIT = 3'd0,
    ST_CFG_CTRL = 3'd1,
    ST_CFG_BAUD = 3'd2,
    ST_IDLE     = 3'd3,
    ST_POLL     = 3'd4,
    ST_SEND     = 3'd5
  } state_t;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO; the head entry is visible until it is popped.
module sync_byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/apb_uart_tx_feeder.sv
// APB master that configures apb_uart and then streams queued bytes into its
// DATA register, polling STATUS for an idle transmitter before every write.
module apb_uart_tx_feeder
  import apb_uart_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int POLL_LIMIT = 1024
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [7:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  output logic        cfg_done,
  output logic        poll_timeout
);

  localparam int CW = $clog2(POLL_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C  = CW'(POLL_LIMIT);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(POLL_LIMIT - 1);
  localparam logic [31:0]   BAUD_WORD = 32'(BAUD_DIV);

  state_t        state;
  logic          push;
  logic          pop;
  logic          xfer_done;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_head;
  logic [CW-1:0] poll_cnt;
  logic          prdata_unused;

  assign in_ready      = !fifo_full;
  assign push          = in_valid && in_ready;
  assign xfer_done     = PSEL && PENABLE && PREADY;
  assign pop           = (state == ST_SEND) && xfer_done;
  assign prdata_unused = ^(PRDATA & ~(32'd1 << TX_BUSY_BIT));

  sync_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Configuration writes run back to back; every later transfer is followed
  // by a cycle with PSEL low before the next SETUP.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state        <= ST_RST_WAIT;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      cfg_done     <= 1'b0;
      poll_timeout <= 1'b0;
      poll_cnt     <= '0;
    end else begin
      unique case (state)
        ST_RST_WAIT: begin
          state   <= ST_CFG_CTRL;
          PSEL    <= 1'b1;
          PENABLE <= 1'b0;
          PWRITE  <= 1'b1;
          PADDR   <= ADDR_CTRL;
          PWDATA  <= CTRL_ENABLE;
        end
        ST_CFG_CTRL: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            state   <= ST_CFG_BAUD;
            PENABLE <= 1'b0;
            PADDR   <= ADDR_BAUD;
            PWDATA  <= BAUD_WORD;
          end
        end
        ST_CFG_BAUD: begin
          if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            state    <= ST_IDLE;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            cfg_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          // A byte being pushed this cycle is enough to start polling.
          if (!fifo_empty || push) begin
            state  <= ST_POLL;
            PSEL   <= 1'b1;
            PWRITE <= 1'b0;
            PADDR  <= ADDR_STATUS;
            PWDATA <= '0;
          end
        end
        ST_POLL: begin
          if (!PSEL) begin
            PSEL   <= 1'b1;
            PWRITE <= 1'b0;
            PADDR  <= ADDR_STATUS;
            PWDATA <= '0;
          end else if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            if (PRDATA[TX_BUSY_BIT]) begin
              if (poll_cnt != LIMIT_C) poll_cnt <= poll_cnt + 1'b1;
              if (poll_cnt >= LIMIT_M1) poll_timeout <= 1'b1;
            end else begin
              poll_cnt <= '0;
              state    <= ST_SEND;
            end
          end
        end
        ST_SEND: begin
          if (!PSEL) begin
            PSEL   <= 1'b1;
            PWRITE <= 1'b1;
            PADDR  <= ADDR_DATA;
            PWDATA <= {24'b0, fifo_head};
          end else if (!PENABLE) begin
            PENABLE <= 1'b1;
          end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_RST_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_tx_feeder.sv
// Directed bench for apb_uart_tx_feeder with a small APB slave model.
module tb_apb_uart_tx_feeder;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } xfer_t;

  logic        PCLK;
  logic        PRESET;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        cfg_done;
  logic        poll_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model state
  int    wait_states = 0;
  int    wait_cnt    = 0;
  int    busy_left   = 0;
  bit    acc_pending = 0;
  bit    done_prev   = 0;
  logic [40:0] lat;
  xfer_t log_q[$];

  apb_uart_tx_feeder #(
    .BAUD_DIV   (16),
    .FIFO_DEPTH (8),
    .POLL_LIMIT (4)
  ) dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .cfg_done     (cfg_done),
    .poll_timeout (poll_timeout)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [42:0] bus();
    return {PSEL, PENABLE, PWRITE, PADDR, PWDATA};
  endfunction

  function automatic xfer_t mk(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    xfer_t x;
    x.wr = wr; x.addr = addr; x.data = data;
    return x;
  endfunction

  function automatic int count_writes(input int base);
    int n = 0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].wr) n++;
    return n;
  endfunction

  // APB slave: wait states, busy countdown on STATUS reads, and field stability checks
  always @(negedge PCLK) begin
    if (PRESET) begin
      PREADY      = 1'b0;
      wait_cnt    = 0;
      acc_pending = 0;
      done_prev   = 0;
    end else begin
      if (acc_pending) check("acc_hold", {PSEL, PENABLE}, 2'b11);
      if (done_prev) check("acc_end", PENABLE, 1'b0);
      done_prev = 0;
      if (PSEL && !PENABLE) begin
        lat         = {PWRITE, PADDR, PWDATA};
        PREADY      = 1'b0;
        wait_cnt    = 0;
        acc_pending = 0;
      end else if (PSEL && PENABLE) begin
        check("acc_stable", {PWRITE, PADDR, PWDATA}, lat);
        if (wait_cnt >= wait_states) begin
          PREADY = 1'b1;
          if (!PWRITE) begin
            PRDATA = 32'hFFFF_FFFE | ((busy_left > 0) ? 32'd1 : 32'd0);
            if (busy_left > 0) busy_left--;
            log_q.push_back(mk(1'b0, PADDR, PRDATA));
          end else begin
            log_q.push_back(mk(1'b1, PADDR, PWDATA));
          end
          wait_cnt    = 0;
          acc_pending = 0;
          done_prev   = 1;
        end else begin
          PREADY      = 1'b0;
          wait_cnt++;
          acc_pending = 1;
        end
      end else begin
        PREADY      = 1'b0;
        acc_pending = 0;
      end
    end
  end

  task automatic push(input logic [7:0] b, output bit acc);
    @(negedge PCLK);
    in_data  = b;
    in_valid = 1'b1;
    acc      = in_ready;
    @(posedge PCLK);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (log_q.size() >= n) break;
      @(negedge PCLK);
    end
    check(tag, (log_q.size() >= n), 1'b1);
  endtask

  initial begin
    int  base;
    bit  acc;
    bit  got9;
    int  nwr;
    bit  found;
    int  wi;
    xfer_t exp3 [7];

    PRESET   = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    PREADY   = 1'b0;
    PRDATA   = 32'h0;

    // Reset values
    repeat (3) @(negedge PCLK);
    check("rst_bus", bus(), 43'h0);
    check("rst_flags", {cfg_done, poll_timeout, in_ready}, 3'b001);

    // Configuration timeline, PREADY high
    PRESET = 1'b0;
    check("cyc0_idle", PSEL, 1'b0);
    @(negedge PCLK);
    check("cyc1_ctrl_setup", bus(), {1'b1, 1'b0, 1'b1, 8'h00, 32'd1});
    @(negedge PCLK);
    check("cyc2_ctrl_access", bus(), {1'b1, 1'b1, 1'b1, 8'h00, 32'd1});
    @(negedge PCLK);
    check("cyc3_baud_setup", bus(), {1'b1, 1'b0, 1'b1, 8'h04, 32'd16});
    check("cyc3_cfg_done", cfg_done, 1'b0);
    @(negedge PCLK);
    check("cyc4_baud_access", bus(), {1'b1, 1'b1, 1'b1, 8'h04, 32'd16});
    @(negedge PCLK);
    check("cyc5_psel", PSEL, 1'b0);
    check("cyc5_cfg_done", cfg_done, 1'b1);
    repeat (10) @(negedge PCLK);
    check("cfg_log_size", log_q.size(), 2);
    check("cfg_log0", log_q[0], mk(1'b1, 8'h00, 32'd1));
    check("cfg_log1", log_q[1], mk(1'b1, 8'h04, 32'd16));

    // Single byte, UART idle
    base = log_q.size();
    busy_left = 0;
    push(8'h55, acc);
    check("t2_accept", acc, 1'b1);
    @(negedge PCLK);
    check("t2_poll_setup", {PSEL, PENABLE, PWRITE, PADDR}, {1'b1, 1'b0, 1'b0, 8'h0C});
    repeat (3) @(negedge PCLK);
    check("t2_send_setup", bus(), {1'b1, 1'b0, 1'b1, 8'h08, 32'h55});
    @(negedge PCLK);
    check("t2_send_access", bus(), {1'b1, 1'b1, 1'b1, 8'h08, 32'h55});
    wait_log(base + 2, 20, "t2_wait");
    repeat (10) @(negedge PCLK);
    check("t2_log_size", log_q.size(), base + 2);
    check("t2_read", log_q[base], mk(1'b0, 8'h0C, 32'hFFFF_FFFE));
    check("t2_write", log_q[base + 1], mk(1'b1, 8'h08, 32'h55));
    check("t2_empty", in_ready, 1'b1);

    // Three busy reads, two bytes queued
    base = log_q.size();
    busy_left = 3;
    push(8'hA1, acc);
    push(8'hB2, acc);
    exp3[0] = mk(1'b0, 8'h0C, 32'hFFFF_FFFF);
    exp3[1] = mk(1'b0, 8'h0C, 32'hFFFF_FFFF);
    exp3[2] = mk(1'b0, 8'h0C, 32'hFFFF_FFFF);
    exp3[3] = mk(1'b0, 8'h0C, 32'hFFFF_FFFE);
    exp3[4] = mk(1'b1, 8'h08, 32'hA1);
    exp3[5] = mk(1'b0, 8'h0C, 32'hFFFF_FFFE);
    exp3[6] = mk(1'b1, 8'h08, 32'hB2);
    wait_log(base + 7, 200, "t3_wait");
    repeat (10) @(negedge PCLK);
    check("t3_log_size", log_q.size(), base + 7);
    for (int i = 0; i < 7; i++)
      if (base + i < log_q.size()) check($sformatf("t3_x%0d", i), log_q[base + i], exp3[i]);
    check("t3_no_timeout", poll_timeout, 1'b0);

    // Wait states: four low PREADY cycles per ACCESS
    base = log_q.size();
    wait_states = 4;
    push(8'h3C, acc);
    wait_log(base + 2, 100, "t4_wait");
    repeat (5) @(negedge PCLK);
    check("t4_log_size", log_q.size(), base + 2);
    if (log_q.size() >= base + 2) begin
      check("t4_read", log_q[base], mk(1'b0, 8'h0C, 32'hFFFF_FFFE));
      check("t4_write", log_q[base + 1], mk(1'b1, 8'h08, 32'h3C));
    end
    wait_states = 0;

    // Fill FIFO while stalled busy, poll timeout, then drain
    base = log_q.size();
    busy_left = 1000;
    for (int i = 0; i < 8; i++) begin
      push(8'h10 + 8'(i), acc);
      check($sformatf("t5_push%0d", i), acc, 1'b1);
    end
    @(negedge PCLK);
    check("t5_full", in_ready, 1'b0);
    wait_log(base + 3, 100, "t5_wait3");
    @(negedge PCLK);
    check("t5_timeout_3", poll_timeout, 1'b0);
    wait_log(base + 4, 100, "t5_wait4");
    @(negedge PCLK);
    check("t5_timeout_4", poll_timeout, 1'b1);
    check("t5_no_send_yet", count_writes(base), 0);
    busy_left = 0;
    got9 = 0;
    nwr  = -1;
    for (int i = 0; i < 300 && !got9; i++) begin
      @(negedge PCLK);
      in_data  = 8'h18;
      in_valid = 1'b1;
      if (in_ready) begin
        got9 = 1;
        nwr  = count_writes(base);
        @(posedge PCLK);
        #1;
      end
    end
    in_valid = 1'b0;
    check("t5_9th_accepted", got9, 1'b1);
    check("t5_9th_after_send", nwr, 1);
    for (int i = 0; i < 400; i++) begin
      if (count_writes(base) >= 9) break;
      @(negedge PCLK);
    end
    check("t5_writes", count_writes(base), 9);
    wi = 0;
    for (int i = base; i < log_q.size(); i++) begin
      if (log_q[i].wr) begin
        check($sformatf("t5_byte%0d", wi), {log_q[i].addr, log_q[i].data}, {8'h08, 32'h10 + 32'(wi)});
        wi++;
      end
    end
    check("t5_sticky", poll_timeout, 1'b1);

    // Reset during a DATA ACCESS
    wait_states = 20;
    push(8'h77, acc);
    push(8'h88, acc);
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PWRITE && PADDR == 8'h08) begin
        found = 1;
        break;
      end
    end
    check("t6_data_access", found, 1'b1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("t6_bus_zero", bus(), 43'h0);
    check("t6_flags", {cfg_done, poll_timeout, in_ready}, 3'b001);
    wait_states = 0;
    @(negedge PCLK);
    PRESET = 1'b0;
    base = log_q.size();
    wait_log(base + 2, 20, "t6_wait_cfg");
    repeat (20) @(negedge PCLK);
    check("t6_log_size", log_q.size(), base + 2);
    if (log_q.size() >= base + 2) begin
      check("t6_ctrl", log_q[base], mk(1'b1, 8'h00, 32'd1));
      check("t6_baud", log_q[base + 1], mk(1'b1, 8'h04, 32'd16));
    end
    check("t6_flushed", {in_ready, PSEL, cfg_done}, 3'b101);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
